score_counter: RTL

- Two-digit BCD up-counting score keeper for the whack-a-mole game; the count-up counterpart of the game countdown timer.
- Counts hit and bonus events while a game is active and decrements on misses.
- Latches the best score when the game ends.
- BCD outputs feed the display path alongside the timer digits.

---
 rtl/whack_pkg.sv | 16 +
 rtl/bcd_add_sat.sv | 61 ++++++
 rtl/score_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole score path.
package whack_pkg;

  // Game-level FSM states for the score keeper.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    END  = 2'd2
  } state_t;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_add_sat.sv
// Two-digit BCD adder for a small signed delta (-1..+9), clamped to
// [00, max_tens:max_ones] with no wrap in either direction.
module bcd_add_sat
  import whack_pkg::*;
(
  input  bcd_t              a_tens,
  input  bcd_t              a_ones,
  input  logic signed [4:0] delta,
  input  bcd_t              max_tens,
  input  bcd_t              max_ones,
  output bcd_t              sum_tens,
  output bcd_t              sum_ones
);

  logic signed [5:0] ones_sum_s;
  logic signed [5:0] ones_adj_s;
  bcd_t              raw_tens_s;
  bcd_t              raw_ones_s;
  logic              under_s;
  logic              over_s;

  // Ones digit sum with carry/borrow into tens, then clamp to floor/ceiling.
  always_comb begin
    ones_sum_s = $signed({2'b00, a_ones}) + $signed({delta[4], delta});
    ones_adj_s = ones_sum_s - 6'sd10;
    raw_tens_s = a_tens;
    raw_ones_s = a_ones;
    under_s    = 1'b0;
    over_s     = 1'b0;
    if (ones_sum_s < 6'sd0) begin
      if (a_tens == 4'd0) begin
        under_s = 1'b1;
      end else begin
        raw_tens_s = a_tens - 4'd1;
        raw_ones_s = DIGIT_MAX;
      end
    end else if (ones_sum_s > 6'sd9) begin
      if (a_tens == DIGIT_MAX) begin
        over_s = 1'b1;
      end else begin
        raw_tens_s = a_tens + 4'd1;
        raw_ones_s = ones_adj_s[3:0];
      end
    end else begin
      raw_ones_s = ones_sum_s[3:0];
    end

    // Digits are BCD, so {tens, ones} compares correctly as an 8-bit value.
    if (under_s) begin
      sum_tens = 4'd0;
      sum_ones = 4'd0;
    end else if (over_s || ({raw_tens_s, raw_ones_s} > {max_tens, max_ones})) begin
      sum_tens = max_tens;
      sum_ones = max_ones;
    end else begin
      sum_tens = raw_tens_s;
      sum_ones = raw_ones_s;
    end
  end

endmodule

// File: rtl/score_counter.sv
// Two-digit BCD score keeper: counts hits/bonuses, subtracts misses while a
// game is in play, and latches the best score when a game ends.
module score_counter
  import whack_pkg::*;
#(
  parameter int BONUS_VALUE = 5,
  parameter int MAX_TENS    = 9,
  parameter int MAX_ONES    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       hit,
  input  logic       bonus_hit,
  input  logic       miss,
  input  logic       clear_high,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] high_tens,
  output logic [3:0] high_ones,
  output logic       new_high,
  output logic       saturated
);

  localparam bcd_t MAX_T = 4'(MAX_TENS);
  localparam bcd_t MAX_O = 4'(MAX_ONES);
  localparam logic signed [4:0] BONUS_D = 5'(BONUS_VALUE);

  state_t            state_r, state_nxt_s;
  bcd_t              score_tens_r, score_ones_r, score_tens_nxt_s, score_ones_nxt_s;
  bcd_t              high_tens_r, high_ones_r, high_tens_nxt_s, high_ones_nxt_s;
  logic              new_high_r, new_high_nxt_s;
  logic signed [4:0] inc_s, dec_s, delta_s;
  bcd_t              sum_tens_s, sum_ones_s;

  // Net event delta: bonus wins over hit, miss subtracts one.
  always_comb begin
    if (bonus_hit) begin
      inc_s = BONUS_D;
    end else if (hit) begin
      inc_s = 5'sd1;
    end else begin
      inc_s = 5'sd0;
    end
    dec_s   = miss ? 5'sd1 : 5'sd0;
    delta_s = inc_s - dec_s;
  end

  bcd_add_sat u_add (
    .a_tens   (score_tens_r),
    .a_ones   (score_ones_r),
    .delta    (delta_s),
    .max_tens (MAX_T),
    .max_ones (MAX_O),
    .sum_tens (sum_tens_s),
    .sum_ones (sum_ones_s)
  );

  // Next-state, score and high-score update logic.
  always_comb begin
    state_nxt_s      = state_r;
    score_tens_nxt_s = score_tens_r;
    score_ones_nxt_s = score_ones_r;
    high_tens_nxt_s  = high_tens_r;
    high_ones_nxt_s  = high_ones_r;
    new_high_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (game_active) begin
          state_nxt_s      = PLAY;
          score_tens_nxt_s = 4'd0;
          score_ones_nxt_s = 4'd0;
        end else if (clear_high) begin
          high_tens_nxt_s = 4'd0;
          high_ones_nxt_s = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PLAY: begin
        if (game_active) begin
          score_tens_nxt_s = sum_tens_s;
          score_ones_nxt_s = sum_ones_s;
        end else begin
          // Falling game_active freezes the score; events this cycle drop.
          state_nxt_s = END;
        end
      end
      END: begin
        state_nxt_s = IDLE;
        if ({score_tens_r, score_ones_r} > {high_tens_r, high_ones_r}) begin
          high_tens_nxt_s = score_tens_r;
          high_ones_nxt_s = score_ones_r;
          new_high_nxt_s  = 1'b1;
        end else begin
          new_high_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and digit registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      score_tens_r <= 4'd0;
      score_ones_r <= 4'd0;
      high_tens_r  <= 4'd0;
      high_ones_r  <= 4'd0;
      new_high_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      score_tens_r <= score_tens_nxt_s;
      score_ones_r <= score_ones_nxt_s;
      high_tens_r  <= high_tens_nxt_s;
      high_ones_r  <= high_ones_nxt_s;
      new_high_r   <= new_high_nxt_s;
    end
  end

  assign score_tens = score_tens_r;
  assign score_ones = score_ones_r;
  assign high_tens  = high_tens_r;
  assign high_ones  = high_ones_r;
  assign new_high   = new_high_r;
  assign saturated  = (score_tens_r == MAX_T) && (score_ones_r == MAX_O);

endmodule
